add8_byte_sequencer: RTL

- Multi-byte adder front/back end for the 8-bit ripple adder `add8`.
- Accepts wide operands over a valid/ready handshake and feeds them to an external `add8` instance one byte per clock, least significant byte first.
- Chains `cout` back into `cin` through a register and collects each byte's `sum` into a wide result.
- Sits directly upstream and downstream of `add8`: it drives `add8`'s a/b/cin and consumes `add8`'s sum/cout.

---
 rtl/add8_byte_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/add8_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : add8_byte_sequencer
// Brief    : Serialises wide operands through an external 8-bit add8 adder,
//            LSB first. It chains carry through a register and gathers the
//            per-byte sums into a registered wide result.
// Revision : 1.0 - initial release
// ============================================================================
module add8_byte_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // operand request
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  op_cin,
  // external add8 slice
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout,
  // result
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  result_cout
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;

  // Bit offset of the current byte; idx never exceeds NBYTES-1 so this
  // always selects an in-range slice.
  logic [IDX_W+2:0] byte_lsb;
  assign byte_lsb = {idx, 3'b000};

  // Accept only while idle; a held in_valid simply waits for this.
  assign in_ready = (state == IDLE);

  // Drive the adder only during RUN so it sees quiet zeros otherwise.
  always_comb begin
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[byte_lsb +: 8];
      add_b   = b_reg[byte_lsb +: 8];
      add_cin = carry;
    end
  end

  // Sequencer FSM: latch operands, walk the bytes, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      result      <= '0;
      result_cout <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= op_a;
            b_reg  <= op_b;
            carry  <= op_cin;
            idx    <= '0;
            result <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          result[byte_lsb +: 8] <= add_sum;
          carry                 <= add_cout;
          if (idx == LAST_IDX) begin
            // Final slice: its carry-out is the carry-out of the wide sum.
            result_cout <= add_cout;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
